// File: rtl/boss_ctrl.sv
// boss_ctrl: stage-3 boss movement, animation, attack, damage and death sequencing
module boss_ctrl #(
    parameter int X_INIT        = 155,
    parameter int Y_INIT        = 20,
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 310,
    parameter int SPEED         = 2,
    parameter int HP_INIT       = 8,
    parameter int ANIM_DIV      = 8,
    parameter int ATTACK_PERIOD = 120,
    parameter int HURT_TICKS    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] state,
    input  logic       frame_tick,
    input  logic       hit,
    output logic [8:0] boss_x,
    output logic [8:0] boss_y,
    output logic [3:0] boss_state,
    output logic [3:0] boss_hp,
    output logic       boss_dead,
    output logic       fire,
    output logic [8:0] fire_x,
    output logic [8:0] fire_y
);
    typedef enum logic [2:0] {OFF, MOVE, ATTACK, HURT, DYING, DEAD} fsm_t;

    localparam logic [7:0] A_LAST = 8'(ANIM_DIV - 1);
    localparam logic [7:0] P_LAST = 8'(ATTACK_PERIOD - 1);
    localparam logic [7:0] H_LAST = 8'(HURT_TICKS - 1);
    localparam logic [9:0] XMAX10 = 10'(X_MAX);
    localparam logic [9:0] XLEFT10 = 10'(X_MIN + SPEED);
    localparam logic [9:0] SPEED10 = 10'(SPEED);

    fsm_t       fsm, fsm_n;
    logic [8:0] x, x_n;
    logic       dir, dir_n;
    logic [3:0] bs, bs_n, hp, hp_n;
    logic [7:0] anim, anim_n, at, at_n, hc, hc_n;
    logic       dead, dead_n, fire_r, fire_n;
    logic       wrap;
    logic [7:0] anim_inc;

    assign wrap       = anim == A_LAST;
    assign anim_inc   = wrap ? 8'd0 : anim + 8'd1;
    assign boss_x     = x;
    assign boss_y     = 9'(Y_INIT);
    assign boss_state = bs;
    assign boss_hp    = hp;
    assign boss_dead  = dead;
    assign fire       = fire_r;
    assign fire_x     = x + 9'd4;
    assign fire_y     = 9'(Y_INIT) + 9'd10;

    // State register; reset and stage-exit both land on the same values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm    <= OFF;
            x      <= 9'(X_INIT);
            dir    <= 1'b1;
            bs     <= 4'd0;
            hp     <= 4'(HP_INIT);
            anim   <= 8'd0;
            at     <= 8'd0;
            hc     <= 8'd0;
            dead   <= 1'b0;
            fire_r <= 1'b0;
        end else begin
            fsm    <= fsm_n;
            x      <= x_n;
            dir    <= dir_n;
            bs     <= bs_n;
            hp     <= hp_n;
            anim   <= anim_n;
            at     <= at_n;
            hc     <= hc_n;
            dead   <= dead_n;
            fire_r <= fire_n;
        end
    end

    // Next state: stage exit first, then a damaging hit (which swallows any tick), then per-state tick handling
    always_comb begin
        fsm_n  = fsm;
        x_n    = x;
        dir_n  = dir;
        bs_n   = bs;
        hp_n   = hp;
        anim_n = anim;
        at_n   = at;
        hc_n   = hc;
        dead_n = dead;
        fire_n = 1'b0;
        if (state != 4'd6) begin
            fsm_n  = OFF;
            x_n    = 9'(X_INIT);
            dir_n  = 1'b1;
            bs_n   = 4'd0;
            hp_n   = 4'(HP_INIT);
            anim_n = 8'd0;
            at_n   = 8'd0;
            hc_n   = 8'd0;
            dead_n = 1'b0;
        end else if (hit && (fsm == MOVE || fsm == ATTACK)) begin
            at_n   = 8'd0;
            anim_n = 8'd0;
            hc_n   = 8'd0;
            hp_n   = hp > 4'd1 ? hp - 4'd1 : 4'd0;
            fsm_n  = hp > 4'd1 ? HURT : DYING;
            bs_n   = hp > 4'd1 ? 4'd4 : 4'd10;
        end else begin
            case (fsm)
                OFF: fsm_n = MOVE;
                MOVE: if (frame_tick) begin
                    if (at == P_LAST) begin
                        at_n   = 8'd0;
                        anim_n = 8'd0;
                        fsm_n  = ATTACK;
                        bs_n   = 4'd6;
                    end else begin
                        at_n   = at + 8'd1;
                        anim_n = anim_inc;
                        bs_n   = wrap ? {2'b00, bs[1:0] + 2'd1} : bs;
                        if (dir) begin
                            x_n   = {1'b0, x} + SPEED10 >= XMAX10 ? 9'(X_MAX) : x + 9'(SPEED);
                            dir_n = !({1'b0, x} + SPEED10 >= XMAX10);
                        end else begin
                            x_n   = {1'b0, x} < XLEFT10 ? 9'(X_MIN) : x - 9'(SPEED);
                            dir_n = {1'b0, x} < XLEFT10;
                        end
                    end
                end
                ATTACK: if (frame_tick) begin
                    anim_n = anim_inc;
                    if (wrap) begin
                        fsm_n  = bs == 4'd9 ? MOVE : ATTACK;
                        bs_n   = bs == 4'd9 ? 4'd0 : bs + 4'd1;
                        fire_n = bs == 4'd7;
                    end
                end
                HURT: if (frame_tick) begin
                    hc_n   = hc == H_LAST ? 8'd0 : hc + 8'd1;
                    anim_n = 8'd0;
                    fsm_n  = hc == H_LAST ? MOVE : HURT;
                    bs_n   = hc == H_LAST ? 4'd0 : (bs == 4'd4 ? 4'd5 : 4'd4);
                end
                DYING: if (frame_tick) begin
                    anim_n = anim_inc;
                    if (wrap) begin
                        fsm_n  = bs == 4'd13 ? DEAD : DYING;
                        dead_n = bs == 4'd13;
                        bs_n   = bs == 4'd13 ? bs : bs + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_boss_ctrl.sv
// tb_boss_ctrl: directed checks of boss_ctrl motion, attack, damage, death and reset paths
module tb_boss_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] state = 4'd0;
    logic       frame_tick = 1'b0;
    logic       hit = 1'b0;
    logic [8:0] boss_x, boss_y, fire_x, fire_y;
    logic [3:0] boss_state, boss_hp;
    logic       boss_dead, fire;
    int vectors = 0;
    int errs = 0;
    int fire_cnt = 0;
    int last_fx = 0, last_fy = 0, last_bs = 0;

    boss_ctrl dut (
        .clk(clk), .rst_n(rst_n), .state(state), .frame_tick(frame_tick), .hit(hit),
        .boss_x(boss_x), .boss_y(boss_y), .boss_state(boss_state), .boss_hp(boss_hp),
        .boss_dead(boss_dead), .fire(fire), .fire_x(fire_x), .fire_y(fire_y)
    );

    always #5 clk = ~clk;

    // Record every fire pulse and its spawn point just after the edge that raised it
    always @(posedge clk) begin
        #1;
        if (fire) begin
            fire_cnt = fire_cnt + 1;
            last_fx  = int'(fire_x);
            last_fy  = int'(fire_y);
            last_bs  = int'(boss_state);
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            errs = errs + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) frame_tick = 1'b1;
            @(negedge clk) frame_tick = 1'b0;
        end
    endtask

    task automatic pulse_hit();
        @(negedge clk) hit = 1'b1;
        @(negedge clk) hit = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_x"}, 16'(boss_x), 16'd155);
        chk({tag, "_y"}, 16'(boss_y), 16'd20);
        chk({tag, "_bs"}, 16'(boss_state), 16'd0);
        chk({tag, "_hp"}, 16'(boss_hp), 16'd8);
        chk({tag, "_dead"}, 16'(boss_dead), 16'd0);
        chk({tag, "_fire"}, 16'(fire), 16'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;
        state = 4'd6;
        @(negedge clk);
        // Animation wrap and first travel
        ticks(7);
        chk("anim7_bs", 16'(boss_state), 16'd0);
        ticks(1);
        chk("anim8_bs", 16'(boss_state), 16'd1);
        ticks(2);
        chk("t10_x", 16'(boss_x), 16'd175);
        chk("t10_y", 16'(boss_y), 16'd20);
        chk("t10_bs", 16'(boss_state), 16'd1);
        chk("t10_hp", 16'(boss_hp), 16'd8);
        // Right clamp and reversal
        ticks(68);
        chk("t78_x", 16'(boss_x), 16'd310);
        ticks(1);
        chk("t79_x", 16'(boss_x), 16'd308);
        ticks(40);
        chk("t119_x", 16'(boss_x), 16'd228);
        chk("t119_bs", 16'(boss_state), 16'd2);
        // Attack entry, frozen position, single fire pulse
        ticks(1);
        chk("atk_bs", 16'(boss_state), 16'd6);
        chk("atk_x", 16'(boss_x), 16'd228);
        ticks(15);
        chk("atk15_bs", 16'(boss_state), 16'd7);
        chk("atk15_fires", 16'(fire_cnt), 16'd0);
        ticks(1);
        @(negedge clk);
        chk("atk16_bs", 16'(boss_state), 16'd8);
        chk("atk16_fires", 16'(fire_cnt), 16'd1);
        chk("fire_x", 16'(last_fx), 16'd232);
        chk("fire_y", 16'(last_fy), 16'd30);
        chk("fire_bs", 16'(last_bs), 16'd8);
        chk("fire_low", 16'(fire), 16'd0);
        ticks(8);
        chk("atk24_bs", 16'(boss_state), 16'd9);
        ticks(8);
        chk("atk32_bs", 16'(boss_state), 16'd0);
        chk("atk32_x", 16'(boss_x), 16'd228);
        chk("atk_total_fires", 16'(fire_cnt), 16'd1);
        ticks(1);
        chk("resume_x", 16'(boss_x), 16'd226);
        // Hurt window
        pulse_hit();
        chk("hurt_hp", 16'(boss_hp), 16'd7);
        chk("hurt_bs", 16'(boss_state), 16'd4);
        ticks(1);
        chk("hurt_t1_bs", 16'(boss_state), 16'd5);
        pulse_hit();
        chk("hurt_rehit_hp", 16'(boss_hp), 16'd7);
        ticks(1);
        chk("hurt_t2_bs", 16'(boss_state), 16'd4);
        chk("hurt_x", 16'(boss_x), 16'd226);
        ticks(13);
        chk("hurt_t15_bs", 16'(boss_state), 16'd5);
        ticks(1);
        chk("hurt_end_bs", 16'(boss_state), 16'd0);
        ticks(1);
        chk("hurt_resume_x", 16'(boss_x), 16'd224);
        // Hit coincident with tick: hit wins, no move
        @(negedge clk) begin hit = 1'b1; frame_tick = 1'b1; end
        @(negedge clk) begin hit = 1'b0; frame_tick = 1'b0; end
        chk("coinc_x", 16'(boss_x), 16'd224);
        chk("coinc_hp", 16'(boss_hp), 16'd6);
        chk("coinc_bs", 16'(boss_state), 16'd4);
        // Wear HP down to one, then kill
        for (int i = 0; i < 5; i++) begin
            ticks(16);
            pulse_hit();
        end
        chk("hp_one", 16'(boss_hp), 16'd1);
        ticks(16);
        pulse_hit();
        chk("die_hp", 16'(boss_hp), 16'd0);
        chk("die_bs", 16'(boss_state), 16'd10);
        chk("die_dead", 16'(boss_dead), 16'd0);
        ticks(8);
        chk("die8_bs", 16'(boss_state), 16'd11);
        pulse_hit();
        chk("die_hit_hp", 16'(boss_hp), 16'd0);
        ticks(23);
        chk("die31_bs", 16'(boss_state), 16'd13);
        chk("die31_dead", 16'(boss_dead), 16'd0);
        ticks(1);
        chk("dead_flag", 16'(boss_dead), 16'd1);
        chk("dead_bs", 16'(boss_state), 16'd13);
        ticks(5);
        pulse_hit();
        chk("dead_hold_bs", 16'(boss_state), 16'd13);
        chk("dead_hold_flag", 16'(boss_dead), 16'd1);
        chk("dead_hold_hp", 16'(boss_hp), 16'd0);
        // Stage exit reloads everything
        @(negedge clk) state = 4'd8;
        @(negedge clk);
        chk_reset("exit_dead");
        state = 4'd6;
        @(negedge clk);
        ticks(120);
        chk("atk2_bs", 16'(boss_state), 16'd6);
        ticks(15);
        chk("atk2_bs7", 16'(boss_state), 16'd7);
        @(negedge clk) begin frame_tick = 1'b1; state = 4'd8; end
        @(negedge clk) frame_tick = 1'b0;
        @(negedge clk);
        chk_reset("exit_atk");
        chk("exit_atk_fires", 16'(fire_cnt), 16'd1);
        // Async reset mid-death
        state = 4'd6;
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            pulse_hit();
            ticks(16);
        end
        pulse_hit();
        chk("die2_bs", 16'(boss_state), 16'd10);
        ticks(3);
        #2 rst_n = 1'b0;
        #1 chk_reset("async");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_bs", 16'(boss_state), 16'd0);
        chk("post_rst_x", 16'(boss_x), 16'd155);
        chk("total_fires", 16'(fire_cnt), 16'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
